// File: rtl/ad9361_ssi_pkg.sv
// rtl/ad9361_ssi_pkg.sv - shared types, widths and word selection for the AD9361 RX port generator
package ad9361_ssi_pkg;

    localparam int LANE_WIDTH   = 6;
    localparam int SAMPLE_WIDTH = 12;
    localparam int SET_WIDTH    = 4 * SAMPLE_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Index of the final word of a frame: 4 words per frame in 1R1T, 8 in 2R2T.
    function automatic logic [2:0] last_word(input logic mode);
        return mode ? 3'd7 : 3'd3;
    endfunction

    // Frame strobe: high on the first half of the frame in 1R1T, on the ch0 half in 2R2T.
    function automatic logic frame_bit(input logic [2:0] wc, input logic mode);
        return mode ? ~wc[2] : ~wc[1];
    endfunction

    // Picks the 6-bit word for position wc: I hi, Q hi, I lo, Q lo; ch1 occupies words 4-7 in 2R2T.
    function automatic logic [LANE_WIDTH-1:0] word_sel(
        input logic [SET_WIDTH-1:0] smp_set,
        input logic [2:0]           wc,
        input logic                 mode
    );
        logic [SAMPLE_WIDTH-1:0] i_s;
        logic [SAMPLE_WIDTH-1:0] q_s;
        logic [LANE_WIDTH-1:0]   w;
        if (mode && wc[2]) begin
            i_s = smp_set[3*SAMPLE_WIDTH-1:2*SAMPLE_WIDTH];
            q_s = smp_set[4*SAMPLE_WIDTH-1:3*SAMPLE_WIDTH];
        end else begin
            i_s = smp_set[SAMPLE_WIDTH-1:0];
            q_s = smp_set[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
        end
        case (wc[1:0])
            2'd0:    w = i_s[SAMPLE_WIDTH-1:LANE_WIDTH];
            2'd1:    w = q_s[SAMPLE_WIDTH-1:LANE_WIDTH];
            2'd2:    w = i_s[LANE_WIDTH-1:0];
            default: w = q_s[LANE_WIDTH-1:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ad9361_sample_fifo.sv
// rtl/ad9361_sample_fifo.sv - synchronous sample-set FIFO with registered ready/empty flags
module ad9361_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             ready_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             empty_q;
    logic             ready_q;
    logic             do_push;
    logic             do_pop;

    // Pushes are gated by the registered ready flag, pops by the registered empty flag.
    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && !empty_q;
    assign count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);

    assign head_o  = mem_q[rptr_q];
    assign empty_o = empty_q;
    assign ready_o = ready_q;

    // Pointer, occupancy and flag registers; ready stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            ready_q <= (count_d != FULL_COUNT);
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ad9361_rx_port_gen.sv
// rtl/ad9361_rx_port_gen.sv - device-side AD9361 RX data port generator (frame + 6-bit words)
module ad9361_rx_port_gen
    import ad9361_ssi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  mode_2r2t,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [SET_WIDTH-1:0]  s_data,
    output logic                  rx_frame,
    output logic [LANE_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  underflow,
    output logic [15:0]           underflow_count
);

    logic                  fifo_pop;
    logic [SET_WIDTH-1:0]  fifo_head;
    logic                  fifo_empty;

    state_t                state_q;
    state_t                state_d;
    logic [2:0]            wc_q;
    logic [2:0]            wc_d;
    logic                  mode_q;
    logic                  mode_d;
    logic                  active_q;
    logic                  active_d;
    logic [SET_WIDTH-1:0]  set_q;
    logic [SET_WIDTH-1:0]  set_d;
    logic                  rx_frame_q;
    logic                  rx_frame_d;
    logic [LANE_WIDTH-1:0] rx_data_q;
    logic [LANE_WIDTH-1:0] rx_data_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  underflow_q;
    logic                  underflow_d;
    logic [15:0]           ucount_q;
    logic [15:0]           ucount_d;
    logic                  frame_end;

    ad9361_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SET_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (resetn),
        .push_i      (s_valid),
        .push_data_i (s_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .ready_o     (s_ready)
    );

    // Next-state: FSM, word counter, frame-boundary pop/underflow and the next output word.
    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        mode_d      = mode_q;
        active_d    = active_q;
        set_d       = set_q;
        fifo_pop    = 1'b0;
        underflow_d = 1'b0;
        ucount_d    = ucount_q;
        frame_end   = !active_q || (wc_q == last_word(mode_q));

        case (state_q)
            IDLE: begin
                mode_d   = mode_2r2t;
                wc_d     = 3'd0;
                active_d = 1'b0;
                set_d    = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            default: begin
                if (frame_end) begin
                    if (enable) begin
                        // New frame: mode is sampled here, so mid-frame changes wait for this point.
                        state_d  = RUN;
                        active_d = 1'b1;
                        wc_d     = 3'd0;
                        mode_d   = mode_2r2t;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            set_d    = fifo_head;
                        end else begin
                            set_d       = '0;
                            underflow_d = 1'b1;
                            if (ucount_q != 16'hFFFF) begin
                                ucount_d = ucount_q + 16'd1;
                            end
                        end
                    end else begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                        wc_d     = 3'd0;
                        set_d    = '0;
                    end
                end else begin
                    wc_d = wc_q + 3'd1;
                    if (!enable) begin
                        state_d = DRAIN;
                    end
                end
            end
        endcase

        busy_d     = (state_d != IDLE);
        rx_frame_d = active_d && frame_bit(wc_d, mode_d);
        rx_data_d  = active_d ? word_sel(set_d, wc_d, mode_d) : '0;
    end

    // State and output registers; reset clears everything immediately, even mid-frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wc_q        <= 3'd0;
            mode_q      <= 1'b0;
            active_q    <= 1'b0;
            set_q       <= '0;
            rx_frame_q  <= 1'b0;
            rx_data_q   <= '0;
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
            ucount_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            wc_q        <= wc_d;
            mode_q      <= mode_d;
            active_q    <= active_d;
            set_q       <= set_d;
            rx_frame_q  <= rx_frame_d;
            rx_data_q   <= rx_data_d;
            busy_q      <= busy_d;
            underflow_q <= underflow_d;
            ucount_q    <= ucount_d;
        end
    end

    assign rx_frame        = rx_frame_q;
    assign rx_data         = rx_data_q;
    assign busy            = busy_q;
    assign underflow       = underflow_q;
    assign underflow_count = ucount_q;

endmodule

// File: tb/tb_ad9361_rx_port_gen.sv
// tb/tb_ad9361_rx_port_gen.sv - directed self-checking bench for ad9361_rx_port_gen
module tb_ad9361_rx_port_gen;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        mode_2r2t = 1'b0;
    logic        s_valid = 1'b0;
    logic [47:0] s_data = '0;
    logic        s_ready;
    logic        rx_frame;
    logic [5:0]  rx_data;
    logic        busy;
    logic        underflow;
    logic [15:0] underflow_count;

    int total = 0;
    int bad   = 0;

    localparam logic [47:0] SET1 = {12'h000, 12'h000, 12'hABC, 12'h123};
    localparam logic [47:0] SET2 = {12'hAAA, 12'h555, 12'h000, 12'hFFF};
    localparam logic [47:0] SET4 = {24'h0, 12'h3C5, 12'h5A1};
    localparam logic [47:0] SET6 = {12'hC30, 12'h0F0, 12'h555, 12'h123};

    logic [47:0] bps [5] = '{
        {24'h0, 12'h801, 12'h0FE},
        {24'h0, 12'h7C3, 12'h246},
        {24'h0, 12'h9E1, 12'hF0F},
        {24'h0, 12'h135, 12'hECA},
        {24'h0, 12'h6D2, 12'h1B7}
    };

    always #5 clk = ~clk;

    ad9361_rx_port_gen #(.FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .enable          (enable),
        .mode_2r2t       (mode_2r2t),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .rx_frame        (rx_frame),
        .rx_data         (rx_data),
        .busy            (busy),
        .underflow       (underflow),
        .underflow_count (underflow_count)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected word k of a sample set: I hi, Q hi, I lo, Q lo; k>=4 selects ch1.
    function automatic logic [5:0] wexp(input logic [47:0] s, input int k);
        logic [11:0] i_s;
        logic [11:0] q_s;
        i_s = s[(k / 4) * 24 +: 12];
        q_s = s[(k / 4) * 24 + 12 +: 12];
        case (k % 4)
            0:       return i_s[11:6];
            1:       return q_s[11:6];
            2:       return i_s[5:0];
            default: return q_s[5:0];
        endcase
    endfunction

    task automatic push(input logic [47:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_rdy", 48'(s_ready), 48'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Entered at the negedge showing word 0; returns at the negedge showing the last word.
    task automatic expect_frame(input string tag, input logic [47:0] s, input int n, input logic mode);
        logic ef;
        for (int k = 0; k < n; k++) begin
            ef = mode ? (k < 4) : (k < 2);
            check($sformatf("%s_d%0d", tag, k), 48'(rx_data), 48'(wexp(s, k)));
            check($sformatf("%s_f%0d", tag, k), 48'(rx_frame), 48'(ef));
            if (k < n - 1) @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_frame"}, 48'(rx_frame), 48'd0);
        check({tag, "_data"}, 48'(rx_data), 48'd0);
        check({tag, "_busy"}, 48'(busy), 48'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_to"}, 48'(busy), 48'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int nz;
        int fh;
        int n;
        logic acc_next;
        logic accepted;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_frame", 48'(rx_frame), 48'd0);
        check("rst_data", 48'(rx_data), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_uf", 48'(underflow), 48'd0);
        check("rst_ucnt", 48'(underflow_count), 48'd0);
        check("rst_ready", 48'(s_ready), 48'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("rel_ready", 48'(s_ready), 48'd1);

        // 1R1T single frame, latency 2 clk after enable
        push(SET1);
        enable = 1'b1;
        @(negedge clk);
        check("t1_lat_frame", 48'(rx_frame), 48'd0);
        check("t1_lat_busy", 48'(busy), 48'd1);
        @(negedge clk);
        expect_frame("t1", SET1, 4, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        check_idle("t1_end");
        check("t1_uf", 48'(underflow_count), 48'd0);

        // 2R2T single frame
        mode_2r2t = 1'b1;
        push(SET2);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        expect_frame("t2", SET2, 8, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        check_idle("t2_end");
        mode_2r2t = 1'b0;

        // Underflow: three starved frames
        enable = 1'b1;
        pulses = 0;
        nz = 0;
        fh = 0;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (underflow) pulses++;
            if (rx_data != 6'd0) nz++;
            if (rx_frame) fh++;
            if (pulses == 3) enable = 1'b0;
            if (!enable && !busy) break;
        end
        check("uf_pulses", 48'(pulses), 48'd3);
        check("uf_count", 48'(underflow_count), 48'd3);
        check("uf_nzdata", 48'(nz), 48'd0);
        check("uf_framehi", 48'(fh), 48'd6);
        check("uf_busy", 48'(busy), 48'd0);
        enable = 1'b0;

        // Disable mid-frame at wc=1, with a mode change that must wait for the next frame
        push(SET4);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("md_d0", 48'(rx_data), 48'(wexp(SET4, 0)));
        @(negedge clk);
        check("md_d1", 48'(rx_data), 48'(wexp(SET4, 1)));
        enable = 1'b0;
        mode_2r2t = 1'b1;
        @(negedge clk);
        check("md_d2", 48'(rx_data), 48'(wexp(SET4, 2)));
        check("md_f2", 48'(rx_frame), 48'd0);
        @(negedge clk);
        check("md_d3", 48'(rx_data), 48'(wexp(SET4, 3)));
        check("md_busy3", 48'(busy), 48'd1);
        @(negedge clk);
        check_idle("md_end");
        mode_2r2t = 1'b0;

        // Backpressure: four sets fill the FIFO, the fifth waits for a pop
        for (int k = 0; k < 4; k++) push(bps[k]);
        check("bp_full", 48'(s_ready), 48'd0);
        s_data  = bps[4];
        s_valid = 1'b1;
        enable  = 1'b1;
        @(negedge clk);
        check("bp_hold", 48'(s_ready), 48'd0);
        acc_next = 1'b0;
        accepted = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (acc_next) begin
                s_valid  = 1'b0;
                acc_next = 1'b0;
                accepted = 1'b1;
            end else if (s_valid && s_ready) begin
                acc_next = 1'b1;
            end
            check($sformatf("bp_s%0d_w%0d", k / 4, k % 4), 48'(rx_data), 48'(wexp(bps[k / 4], k % 4)));
        end
        enable = 1'b0;
        check("bp_accepted", 48'(accepted), 48'd1);
        wait_idle("bp");
        check("bp_ucnt", 48'(underflow_count), 48'd3);
        s_valid = 1'b0;

        // Reset mid-frame at wc=5 in 2R2T
        mode_2r2t = 1'b1;
        push(SET6);
        push(SET1);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        repeat (5) @(negedge clk);
        check("rs_pre", 48'(rx_data), 48'(wexp(SET6, 5)));
        resetn = 1'b0;
        #1;
        check("rs_data", 48'(rx_data), 48'd0);
        check("rs_frame", 48'(rx_frame), 48'd0);
        check("rs_busy", 48'(busy), 48'd0);
        check("rs_ready", 48'(s_ready), 48'd0);
        check("rs_ucnt", 48'(underflow_count), 48'd0);
        enable = 1'b0;
        mode_2r2t = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rs_rel_ready", 48'(s_ready), 48'd1);
        check("rs_rel_busy", 48'(busy), 48'd0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("rs_uf", 48'(underflow), 48'd1);
        check("rs_frame0", 48'(rx_frame), 48'd1);
        nz = (rx_data != 6'd0) ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (rx_data != 6'd0) nz++;
        end
        check("rs_stale", 48'(nz), 48'd0);
        enable = 1'b0;
        wait_idle("rs");
        check("rs_ucnt1", 48'(underflow_count), 48'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
